bcd_modn_counter: RTL and testbench

Parametrised N-digit BCD counter with a run-time terminal value, up/down direction and synchronous load. It has an internal prescaler, a terminal-count strobe, a registered binary mirror of the count and per-digit seven-segment outputs. It replaces the fixed two-model counter in the top-level display path. A single instance covers any modulus up to 10^DIGITS.

---
 rtl/bcd_cnt_pkg.sv | 31 +++
 rtl/bcd_seg7_dec.sv | 27 ++
 rtl/bcd_modn_counter.sv | 131 +++++++++++++
 tb/tb_bcd_modn_counter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the BCD modulus counter and its segment decoders.
// Digit saturation and BCD-to-binary accumulation live here so every user agrees on them.
package bcd_cnt_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] i_digit);
    return (i_digit > BCD_MAX) ? BCD_MAX : i_digit;
  endfunction

  // One Horner step: fold the next (less significant) digit into a running binary value.
  function automatic logic [31:0] bcd_to_bin(input logic [31:0] i_acc,
                                             input logic [BCD_W-1:0] i_digit);
    return (i_acc * 32'd10) + {28'd0, i_digit};
  endfunction

endpackage

// File: rtl/bcd_seg7_dec.sv
// Single-digit BCD to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
// Codes 10..15 decode to blank; the counter never produces them.
module bcd_seg7_dec
  import bcd_cnt_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_modn_counter.sv
// N-digit BCD up/down counter with run-time terminal value, prescaler, synchronous load,
// one-cycle step/wrap strobes, registered binary mirror and per-digit seven-segment outputs.
module bcd_modn_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int DIV_WIDTH = 25,
  parameter int DIV_COEFF = 4,
  parameter int BIN_WIDTH = 12
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    cnt_en,
  input  logic                    cnt_dir,
  input  logic [BCD_W*DIGITS-1:0] cnt_term,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic [BIN_WIDTH-1:0]    num_bin,
  output logic                    cnt_clk,
  output logic                    tc,
  output logic [7*DIGITS-1:0]     seg
);

  localparam int                   VW       = BCD_W * DIGITS;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COEFF - 1);

  logic [VW-1:0]        r_bcd;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_cnt_clk;
  logic                 r_tc;

  logic [VW-1:0]        w_term;
  logic [VW-1:0]        w_load_val;
  logic [VW-1:0]        w_inc;
  logic [VW-1:0]        w_dec;
  logic [DIGITS-1:0]    w_carry;
  logic [DIGITS-1:0]    w_borrow;
  logic                 w_step;
  logic                 w_wrap_up;
  logic                 w_wrap_dn;
  logic                 w_wrap;
  logic                 w_update;
  logic [VW-1:0]        w_next;
  logic [31:0]          w_bin_acc;
  logic [BIN_WIDTH-1:0] w_next_bin;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  // Per-digit sanitising, carry/borrow ripple and display decode
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [BCD_W-1:0] w_dig;
    assign w_dig = r_bcd[gi*BCD_W +: BCD_W];

    assign w_term[gi*BCD_W +: BCD_W]     = bcd_sat(cnt_term[gi*BCD_W +: BCD_W]);
    assign w_load_val[gi*BCD_W +: BCD_W] = bcd_sat(load_val[gi*BCD_W +: BCD_W]);

    assign w_inc[gi*BCD_W +: BCD_W] = !w_carry[gi]       ? w_dig :
                                      (w_dig == BCD_MAX) ? 4'd0  : w_dig + 4'd1;
    assign w_dec[gi*BCD_W +: BCD_W] = !w_borrow[gi]      ? w_dig :
                                      (w_dig == 4'd0)    ? BCD_MAX : w_dig - 4'd1;

    if (gi < DIGITS - 1) begin : g_ripple
      assign w_carry[gi+1]  = w_carry[gi]  & (w_dig == BCD_MAX);
      assign w_borrow[gi+1] = w_borrow[gi] & (w_dig == 4'd0);
    end

    bcd_seg7_dec u_seg_dec (
      .i_digit (w_dig),
      .o_seg   (seg[gi*7 +: 7])
    );
  end

  assign w_step = cnt_en & (r_div_cnt == DIV_LAST);

  // With every digit <= 9, packed BCD orders the same way as the numbers it encodes
  assign w_wrap_up = (r_bcd >= w_term);
  assign w_wrap_dn = (r_bcd == '0) | (r_bcd > w_term);
  assign w_wrap    = cnt_dir ? w_wrap_dn : w_wrap_up;
  assign w_update  = load | w_step;

  always_comb begin
    w_next = r_bcd;
    if (load) begin
      w_next = w_load_val;
    end else if (w_step) begin
      if (!cnt_dir) w_next = w_wrap_up ? '0 : w_inc;
      else          w_next = w_wrap_dn ? w_term : w_dec;
    end
  end

  always_comb begin
    w_bin_acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_bin_acc = bcd_to_bin(w_bin_acc, w_next[i*BCD_W +: BCD_W]);
    end
    w_next_bin = BIN_WIDTH'(w_bin_acc);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_div_cnt <= '0;
      r_cnt_clk <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      if (w_update) begin
        r_bcd <= w_next;
        r_bin <= w_next_bin;
      end
      if (load) begin
        r_div_cnt <= '0;
        r_cnt_clk <= 1'b0;
        r_tc      <= 1'b0;
      end else begin
        r_cnt_clk <= w_step;
        r_tc      <= w_step & w_wrap;
        if (cnt_en) r_div_cnt <= w_step ? '0 : r_div_cnt + DIV_WIDTH'(1);
      end
    end
  end

  assign bcd_out = r_bcd;
  assign num_bin = r_bin;
  assign cnt_clk = r_cnt_clk;
  assign tc      = r_tc;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Self-checking bench for bcd_modn_counter: integer reference model checked every cycle,
// a load/sanitise vector table, directed corner sequences and a randomized run.
module tb_bcd_modn_counter;

  localparam int DIGITS    = 3;
  localparam int DIV_WIDTH = 25;
  localparam int DIV_COEFF = 4;
  localparam int BIN_WIDTH = 12;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic                 cnt_en;
  logic                 cnt_dir;
  logic [11:0]          cnt_term;
  logic                 load;
  logic [11:0]          load_val;
  logic [11:0]          bcd_out;
  logic [BIN_WIDTH-1:0] num_bin;
  logic                 cnt_clk;
  logic                 tc;
  logic [20:0]          seg;

  always #5 sys_clk = ~sys_clk;

  bcd_modn_counter #(
    .DIGITS    (DIGITS),
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_COEFF (DIV_COEFF),
    .BIN_WIDTH (BIN_WIDTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cnt_en    (cnt_en),
    .cnt_dir   (cnt_dir),
    .cnt_term  (cnt_term),
    .load      (load),
    .load_val  (load_val),
    .bcd_out   (bcd_out),
    .num_bin   (num_bin),
    .cnt_clk   (cnt_clk),
    .tc        (tc),
    .seg       (seg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers
  int m_val = 0;
  int m_div = 0;
  bit m_clk = 1'b0;
  bit m_tc  = 1'b0;

  typedef struct {
    logic [11:0] lv;
    logic [11:0] exp_bcd;
    int          exp_bin;
  } ld_vec_t;

  ld_vec_t ld_tab[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_val(input logic [11:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = int'(b[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] seg_exp(input int v);
    logic [20:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*7 +: 7] = seg_of(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_val = 0;
    m_div = 0;
    m_clk = 1'b0;
    m_tc  = 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied
  function automatic void model_edge();
    int t;
    t = sat_val(cnt_term);
    if (load) begin
      m_val = sat_val(load_val);
      m_div = 0;
      m_clk = 1'b0;
      m_tc  = 1'b0;
    end else if (!cnt_en) begin
      m_clk = 1'b0;
      m_tc  = 1'b0;
    end else if (m_div == DIV_COEFF - 1) begin
      m_div = 0;
      m_clk = 1'b1;
      if (!cnt_dir) begin
        if (m_val >= t) begin m_val = 0;         m_tc = 1'b1; end
        else            begin m_val = m_val + 1; m_tc = 1'b0; end
      end else begin
        if (m_val == 0 || m_val > t) begin m_val = t;         m_tc = 1'b1; end
        else                         begin m_val = m_val - 1; m_tc = 1'b0; end
      end
    end else begin
      m_div++;
      m_clk = 1'b0;
      m_tc  = 1'b0;
    end
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge sys_clk);
    #1;
    chk("cyc_bcd",     32'(bcd_out), 32'(to_bcd(m_val)));
    chk("cyc_bin",     32'(num_bin), 32'(m_val));
    chk("cyc_cnt_clk", 32'(cnt_clk), 32'(m_clk));
    chk("cyc_tc",      32'(tc),      32'(m_tc));
    chk("cyc_seg",     32'(seg),     32'(seg_exp(m_val)));
  endtask

  task automatic do_load(input logic [11:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_tab[0] = '{12'h9A7, 12'h997, 997};
    ld_tab[1] = '{12'hFFF, 12'h999, 999};
    ld_tab[2] = '{12'h000, 12'h000, 0};
    ld_tab[3] = '{12'h123, 12'h123, 123};
    ld_tab[4] = '{12'h5B0, 12'h590, 590};
    ld_tab[5] = '{12'hC0D, 12'h909, 909};

    sys_rst_n = 1'b0;
    cnt_en    = 1'b0;
    cnt_dir   = 1'b0;
    cnt_term  = 12'h999;
    load      = 1'b0;
    load_val  = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_bcd",     32'(bcd_out), 32'h000);
    chk("rst_bin",     32'(num_bin), 32'd0);
    chk("rst_seg",     32'(seg),     32'h0FDFBF);
    chk("rst_cnt_clk", 32'(cnt_clk), 32'd0);
    chk("rst_tc",      32'(tc),      32'd0);
    sys_rst_n = 1'b1;

    // Asynchronous reset in the middle of counting
    do_load(12'h016);
    cnt_en = 1'b1;
    repeat (4) cyc();
    chk("pre_rst_val", 32'(bcd_out), 32'h017);
    repeat (2) cyc();
    #3 sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_bcd",     32'(bcd_out), 32'h000);
    chk("midrst_bin",     32'(num_bin), 32'd0);
    chk("midrst_seg",     32'(seg),     32'h0FDFBF);
    chk("midrst_cnt_clk", 32'(cnt_clk), 32'd0);
    chk("midrst_tc",      32'(tc),      32'd0);
    @(posedge sys_clk);
    #1;
    chk("rst_hold_bcd", 32'(bcd_out), 32'h000);
    sys_rst_n = 1'b1;
    repeat (3) cyc();
    chk("first_step_early", 32'(bcd_out), 32'h000);
    cyc();
    chk("first_step_val", 32'(bcd_out), 32'h001);
    chk("first_step_clk", 32'(cnt_clk), 32'd1);

    // Up, modulus 24
    cnt_term = 12'h023;
    do_load(12'h020);
    repeat (4) cyc();
    chk("up24_021",     32'(bcd_out), 32'h021);
    chk("up24_clk",     32'(cnt_clk), 32'd1);
    repeat (8) cyc();
    chk("up24_023",     32'(bcd_out), 32'h023);
    chk("up24_bin23",   32'(num_bin), 32'd23);
    repeat (3) cyc();
    chk("up24_pre_tc",  32'(tc),      32'd0);
    cyc();
    chk("up24_wrap",    32'(bcd_out), 32'h000);
    chk("up24_tc",      32'(tc),      32'd1);
    chk("up24_bin0",    32'(num_bin), 32'd0);
    cyc();
    chk("up24_tc_drop", 32'(tc),      32'd0);

    // Down, modulus 150
    cnt_term = 12'h149;
    cnt_dir  = 1'b1;
    do_load(12'h100);
    repeat (4) cyc();
    chk("dn150_099",  32'(bcd_out), 32'h099);
    chk("dn150_bin",  32'(num_bin), 32'd99);
    do_load(12'h001);
    repeat (4) cyc();
    chk("dn150_000",  32'(bcd_out), 32'h000);
    chk("dn150_notc", 32'(tc),      32'd0);
    repeat (4) cyc();
    chk("dn150_wrap", 32'(bcd_out), 32'h149);
    chk("dn150_tc",   32'(tc),      32'd1);
    chk("dn150_b149", 32'(num_bin), 32'd149);

    // Terminal shrinks below the current value
    cnt_dir = 1'b0;
    do_load(12'h120);
    cnt_term = 12'h023;
    repeat (4) cyc();
    chk("shrink_up",    32'(bcd_out), 32'h000);
    chk("shrink_up_tc", 32'(tc),      32'd1);
    do_load(12'h120);
    cnt_dir = 1'b1;
    repeat (4) cyc();
    chk("shrink_dn",    32'(bcd_out), 32'h023);
    chk("shrink_dn_tc", 32'(tc),      32'd1);

    // Load coincident with a step
    cnt_dir  = 1'b0;
    cnt_term = 12'h999;
    do_load(12'h500);
    repeat (3) cyc();
    do_load(12'h250);
    chk("ldstep_val", 32'(bcd_out), 32'h250);
    chk("ldstep_clk", 32'(cnt_clk), 32'd0);
    repeat (3) cyc();
    chk("ldstep_hold", 32'(bcd_out), 32'h250);
    cyc();
    chk("ldstep_next", 32'(bcd_out), 32'h251);
    chk("ldstep_nclk", 32'(cnt_clk), 32'd1);

    // Enable gating mid-prescale
    do_load(12'h300);
    repeat (2) cyc();
    cnt_en = 1'b0;
    repeat (10) cyc();
    chk("gate_frozen", 32'(bcd_out), 32'h300);
    chk("gate_clk",    32'(cnt_clk), 32'd0);
    cnt_en = 1'b1;
    cyc();
    chk("gate_res1", 32'(bcd_out), 32'h300);
    cyc();
    chk("gate_res2", 32'(bcd_out), 32'h301);
    chk("gate_rclk", 32'(cnt_clk), 32'd1);

    // Load / sanitise vector table
    cnt_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_load(ld_tab[i].lv);
      chk("tab_bcd", 32'(bcd_out), 32'(ld_tab[i].exp_bcd));
      chk("tab_bin", 32'(num_bin), 32'(ld_tab[i].exp_bin));
    end

    // Randomized run against the model
    cnt_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) cnt_term = 12'($urandom);
        else                           cnt_term = to_bcd(int'($urandom_range(0, 30)));
      end
      if ($urandom_range(0, 49) == 0) cnt_dir = ~cnt_dir;
      cnt_en   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = 12'($urandom);
      cyc();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
